// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared constants and types for the eight-way round-robin arbiter.
//   N_REQ       : number of requesters
//   IDX_W       : width of a requester index
//   arb_state_e : arbiter FSM states
//   next_idx()  : index increment with natural wrap 7 -> 0
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Priority pointer successor; the 3-bit width makes 7 wrap to 0.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return idx + 3'd1;
    endfunction

endpackage

// File: rtl/decoder_3x8.sv
// -----------------------------------------------------------------------------
// decoder_3x8
// Converts a 3-bit index into a one-hot 8-bit vector, gated by an enable.
//   idx_i : index to decode
//   en_i  : when low the output is all-zero
//   y_o   : one-hot result
// -----------------------------------------------------------------------------
module decoder_3x8 (
    input  logic [2:0] idx_i,
    input  logic       en_i,
    output logic [7:0] y_o
);

    // Index to one-hot conversion.
    always_comb begin
        y_o = 8'h00;
        if (en_i) begin
            case (idx_i)
                3'd0:    y_o = 8'h01;
                3'd1:    y_o = 8'h02;
                3'd2:    y_o = 8'h04;
                3'd3:    y_o = 8'h08;
                3'd4:    y_o = 8'h10;
                3'd5:    y_o = 8'h20;
                3'd6:    y_o = 8'h40;
                3'd7:    y_o = 8'h80;
                default: y_o = 8'h00;
            endcase
        end else begin
            y_o = 8'h00;
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// -----------------------------------------------------------------------------
// rr_arbiter_8
// Eight-way round-robin arbiter with a registered one-hot grant. The winner
// keeps the grant while it keeps requesting; priority rotates to the index
// after the last winner on every release.
//
// Optional feature: define RR_ARBITER_TIMEOUT_EN to limit each grant to
// HOLD_MAX consecutive cycles and pulse timeout_o on the forced release.
//
// Ports:
//   clk_i         : clock, rising edge
//   rst_ni        : asynchronous active-low reset
//   enable_i      : arbitration enable
//   req_i[7:0]    : request vector, bit k = requester k
//   grant_o[7:0]  : one-hot grant or zero (decoded from registered state)
//   grant_idx_o   : index of the current or last winner
//   grant_valid_o : high while a grant is active
//   timeout_o     : one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_valid_o,
    output logic             timeout_o
);

    if (HOLD_MAX < 1) begin : g_bad_hold
        $error("rr_arbiter_8: HOLD_MAX must be at least 1");
    end

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    logic             win_found_s;
    logic [IDX_W-1:0] win_idx_s;
    logic             norm_rel_s;
    logic             en_rel_s;
    logic             limit_s;
    logic             release_s;

`ifdef RR_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_MAX + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Rotating priority search: scan from ptr upward; iterating downward lets
    // the candidate closest to ptr overwrite the others.
    always_comb begin
        logic [IDX_W-1:0] cand_s;
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand_s = ptr_q + i[IDX_W-1:0];
            if (req_i[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Release conditions for the current grant.
    always_comb begin
        norm_rel_s = ~req_i[idx_q];
        en_rel_s   = ~enable_i;
`ifdef RR_ARBITER_TIMEOUT_EN
        limit_s    = (cnt_q == CNT_W'(HOLD_MAX));
`else
        limit_s    = 1'b0;
`endif
        release_s  = norm_rel_s | en_rel_s | limit_s;
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (enable_i && win_found_s) begin
                    state_d = ARB_GRANT;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (release_s) begin
                    state_d = ARB_IDLE;
                end else begin
                    state_d = ARB_GRANT;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // FSM output / datapath next values.
    always_comb begin
        idx_d     = idx_q;
        valid_d   = valid_q;
        ptr_d     = ptr_q;
        timeout_d = 1'b0;
`ifdef RR_ARBITER_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (enable_i && win_found_s) begin
                    idx_d   = win_idx_s;
                    valid_d = 1'b1;
`ifdef RR_ARBITER_TIMEOUT_EN
                    cnt_d   = CNT_W'(1);
`endif
                end else begin
                    valid_d = 1'b0;
                end
            end
            ARB_GRANT: begin
                if (release_s) begin
                    valid_d   = 1'b0;
                    ptr_d     = next_idx(idx_q);
                    // A forced release only counts when nothing else caused it.
                    timeout_d = limit_s & ~norm_rel_s & ~en_rel_s;
                end else begin
                    valid_d   = 1'b1;
`ifdef RR_ARBITER_TIMEOUT_EN
                    cnt_d     = cnt_q + CNT_W'(1);
`endif
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
`ifdef RR_ARBITER_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
`ifdef RR_ARBITER_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    decoder_3x8 u_dec (
        .idx_i (idx_q),
        .en_i  (valid_q),
        .y_o   (grant_o)
    );

    assign grant_idx_o   = idx_q;
    assign grant_valid_o = valid_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter_8
// Scoreboard bench for rr_arbiter_8. Every stimulus cycle advances a reference
// model and queues the outputs expected after the next clock edge; a separate
// monitor pops and compares shortly after each rising edge.
// -----------------------------------------------------------------------------
module tb_rr_arbiter_8;

    localparam int HOLD = 4;
`ifdef RR_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk_i;
    logic       rst_ni;
    logic       enable_i;
    logic [7:0] req_i;
    logic [7:0] grant_o;
    logic [2:0] grant_idx_o;
    logic       grant_valid_o;
    logic       timeout_o;

    rr_arbiter_8 #(.HOLD_MAX(HOLD)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .enable_i      (enable_i),
        .req_i         (req_i),
        .grant_o       (grant_o),
        .grant_idx_o   (grant_idx_o),
        .grant_valid_o (grant_valid_o),
        .timeout_o     (timeout_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [7:0] g;
        logic [2:0] idx;
        logic       v;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: who holds the grant, for how many cycles so far,
    // and where the priority search starts.
    bit m_busy;
    int m_idx;
    int m_ptr;
    int m_hold;
    bit m_to;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Requester with the smallest rotational distance from the pointer wins.
    function automatic int pick(input logic [7:0] r, input int p);
        int best;
        int bestd;
        best  = -1;
        bestd = 99;
        for (int k = 0; k < 8; k++) begin
            if (r[k] && (((k - p + 8) % 8) < bestd)) begin
                bestd = (k - p + 8) % 8;
                best  = k;
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_idx  = 0;
        m_ptr  = 0;
        m_hold = 0;
        m_to   = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic e);
        exp_t x;
        bit   nrel;
        bit   erel;
        bit   lim;
        if (!m_busy) begin
            m_to = 1'b0;
            if (e && (r != 8'h00)) begin
                m_idx  = pick(r, m_ptr);
                m_busy = 1'b1;
                m_hold = 1;
            end
        end else begin
            nrel = (r[m_idx] == 1'b0);
            erel = !e;
            lim  = TO_EN && (m_hold >= HOLD);
            if (nrel || erel || lim) begin
                m_busy = 1'b0;
                m_ptr  = (m_idx + 1) % 8;
                m_to   = lim && !nrel && !erel;
            end else begin
                m_hold = m_hold + 1;
                m_to   = 1'b0;
            end
        end
        x.g   = m_busy ? 8'(1 << m_idx) : 8'h00;
        x.idx = m_idx[2:0];
        x.v   = m_busy;
        x.to  = m_to;
        exp_q.push_back(x);
    endtask

    // One stimulus cycle: drive on the falling edge, let the rising edge and
    // the monitor's comparison happen, then return.
    task automatic step(input logic [7:0] r, input logic e);
        @(negedge clk_i);
        req_i    = r;
        enable_i = e;
        model_step(r, e);
        @(posedge clk_i);
        #2;
    endtask

    // Monitor: compare DUT outputs to the oldest queued expectation.
    always @(posedge clk_i) begin
        exp_t x;
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check("grant_o",       32'(grant_o),       32'(x.g));
            check("grant_idx_o",   32'(grant_idx_o),   32'(x.idx));
            check("grant_valid_o", 32'(grant_valid_o), 32'(x.v));
            check("timeout_o",     32'(timeout_o),     32'(x.to));
        end
    end

    initial begin
        logic [7:0] r;
        logic       e;
        logic       prev_v;
        int         grants;
        int         to_cnt;

        // Reset held with everything requesting.
        rst_ni   = 1'b0;
        req_i    = 8'hFF;
        enable_i = 1'b1;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_grant",   32'(grant_o),       32'h0);
        check("rst_idx",     32'(grant_idx_o),   32'h0);
        check("rst_valid",   32'(grant_valid_o), 32'h0);
        check("rst_timeout", 32'(timeout_o),     32'h0);
        @(negedge clk_i);
        req_i    = 8'h00;
        enable_i = 1'b0;
        rst_ni   = 1'b1;

        // Single requester 2, dropped after five edges.
        for (int i = 0; i < 5; i++) begin
            step(8'h04, 1'b1);
            if (i == 0) check("single_idx", 32'(grant_idx_o), 32'd2);
        end
        step(8'h00, 1'b1);
        step(8'h00, 1'b1);

        // Reset in the middle of a grant clears outputs without a clock edge.
        step(8'h08, 1'b1);
        rst_ni = 1'b0;
        #1;
        check("async_rst_grant", 32'(grant_o),       32'h0);
        check("async_rst_valid", 32'(grant_valid_o), 32'h0);
        check("async_rst_idx",   32'(grant_idx_o),   32'h0);
        model_reset();
        @(negedge clk_i);
        req_i    = 8'h00;
        enable_i = 1'b0;
        rst_ni   = 1'b1;

        // Rotation: all request, each winner drops for one cycle after two
        // granted cycles; expected order 0..7 then 0.
        grants = 0;
        for (int cyc = 0; cyc < 80 && grants < 9; cyc++) begin
            r = 8'hFF;
            if (m_busy && m_hold == 2) r[m_idx] = 1'b0;
            prev_v = grant_valid_o;
            step(r, 1'b1);
            if (grant_valid_o && !prev_v) begin
                check("rot_order", 32'(grant_idx_o), 32'(grants % 8));
                grants++;
            end
        end
        check("rot_grant_count", 32'(grants), 32'd9);
        step(8'h00, 1'b1);

        // Wrap: last winner 6, then 7 beats 0, then 0.
        step(8'h40, 1'b1);
        step(8'h00, 1'b1);
        step(8'h81, 1'b1);
        check("wrap_first", 32'(grant_idx_o), 32'd7);
        step(8'h01, 1'b1);
        step(8'h01, 1'b1);
        check("wrap_second", 32'(grant_idx_o), 32'd0);
        step(8'h00, 1'b1);

        // Enable dropped mid-grant; no new grants while disabled.
        step(8'h08, 1'b1);
        step(8'h08, 1'b1);
        for (int i = 0; i < 5; i++) step(8'hFF, 1'b0);
        check("disabled_valid", 32'(grant_valid_o), 32'h0);
        step(8'h00, 1'b1);

`ifdef RR_ARBITER_TIMEOUT_EN
        // Timeout: 0 held four cycles, one pulse, bubble, then 1.
        step(8'h00, 1'b1);
        to_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            step(8'h03, 1'b1);
            if (timeout_o) to_cnt++;
        end
        check("to_pulses", 32'(to_cnt), 32'd1);
        check("to_second_grant", 32'(grant_o), 32'h02);
        step(8'h00, 1'b1);
`else
        to_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(8'h03, 1'b1);
            if (timeout_o) to_cnt++;
        end
        check("no_to_pulses", 32'(to_cnt), 32'd0);
        check("no_to_held", 32'(grant_o), 32'h01);
        step(8'h00, 1'b1);
`endif

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = 8'h00;
            else                           r = 8'($urandom) & 8'($urandom);
            e = ($urandom_range(0, 7) != 0);
            step(r, e);
        end

        step(8'h00, 1'b0);
        check("queue_drain", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Round-robin arbiter that shares one 8-way one-hot resource select between eight requesters. It registers a single winner, holds the grant while the winner keeps requesting, and rotates priority so every requester is served within bounded time. Its one-hot grant drives downstream select/enable lines; the index-to-one-hot conversion uses the existing 3-to-8 decoder.

## Interface
- `HOLD_MAX`, default 16: maximum consecutive granted cycles per grant. Must be ≥ 1. Used only when the timeout feature is compiled in.
- `clk_i`, input, 1: clock. All state changes on the rising edge.
- `rst_ni`, input, 1: reset. **One clock; reset is asynchronous and active-low.**
- `enable_i`, input, 1: arbitration enable.
- `req_i`, input, 8: request vector. Bit k = requester k.
- `grant_o`, output, 8: registered one-hot grant, or all-zero.
- `grant_idx_o`, output, 3: index of the current or last winner.
- `grant_valid_o`, output, 1: high when `grant_o` ≠ 0.
- `timeout_o`, output, 1: one-cycle pulse on a forced release.

## Operation
- **Reset values:**
  - state ARB_IDLE.
  - `grant_o`=0, `grant_idx_o`=0, `grant_valid_o`=0, `timeout_o`=0.
  - Priority pointer `ptr`=0, hold counter=0.
- **ARB_IDLE:**
  - If `enable_i`=1 and `req_i`≠0, select the first set bit searching ptr, ptr+1, …, ptr+7 (mod 8).
  - Register the winner into `grant_idx_o`/`grant_o`, set `grant_valid_o`, and go to ARB_GRANT.
  - Otherwise stay in ARB_IDLE with outputs at zero (`grant_idx_o` holds its value).
- **ARB_GRANT:** release when any of the following holds:
  - `req_i[grant_idx_o]`=0 (normal release);
  - `enable_i`=0;
  - the hold limit is reached (timeout feature only).
- **On release:**
  - `grant_o`=0 and `grant_valid_o`=0 next cycle; go to ARB_IDLE.
  - `ptr` ← `grant_idx_o`+1, wrapping 7→0.
  - Otherwise hold the grant unchanged.
- Requests from non-winners while in ARB_GRANT are ignored and never preempt.
- Simultaneous normal release and hold limit: treat as a normal release, `timeout_o` stays 0.
- Reset asserted mid-grant: all outputs go to their reset values immediately (asynchronously); `ptr` returns to 0.

## Timing
- Grant latency: request sampled at edge N → `grant_o` valid after edge N+1.
- Release latency: request low at edge N → `grant_o`=0 after edge N+1.
- Minimum one ARB_IDLE bubble cycle between consecutive grants. Worst-case wait for a continuously requesting input: 7 full grants plus 8 bubbles.
- `grant_o`, `grant_idx_o`, `grant_valid_o` and `timeout_o` are registered; there is no combinational path from inputs to outputs.

## Configuration
- **`RR_ARBITER_TIMEOUT_EN` defined:**
  - The hold counter (width $clog2(HOLD_MAX+1)) loads 1 on grant and increments each granted cycle.
  - `grant_o` stays high for at most `HOLD_MAX` consecutive cycles.
  - Reaching the limit forces a release; `timeout_o` pulses high in the same cycle `grant_o` drops, and `ptr` advances as normal.
- **Not defined:**
  - No counter; a grant is held indefinitely while requested.
  - `timeout_o` is tied 0 and `HOLD_MAX` is ignored.

## Structure
- Package `arb_pkg` contains:
  - `N_REQ`=8 and `IDX_W`=3;
  - typedef enum `arb_state_e` {ARB_IDLE, ARB_GRANT}.
- One sub-module: `decoder_3x8` instance converts the registered winner index to `grant_o`. Its enable is the registered grant-valid flag.
- Rotating priority search is inline combinational logic.

## Test plan
- Reset: hold `rst_ni`=0 with `req_i`=8'hFF, `enable_i`=1 → all outputs 0. Assert reset mid-grant → `grant_o` clears without waiting for a clock edge.
- Single request: `req_i`=8'h04 from cycle 0, dropped at cycle 5 → `grant_o`=8'h04, `grant_idx_o`=2 after edge 1 through edge 5; `grant_o`=0 after edge 6.
- Rotation: all eight requesters request, and each winner drops its request for one cycle after 2 granted cycles → grant order 0,1,2,…,7,0 with one bubble between grants.
- Wrap: last winner 6 (`ptr`=7), `req_i`=8'h81 → grant 7 first, then 0 after release.
- Enable: grant on 3 active, `enable_i`→0 → `grant_o`=0 next cycle, and no new grant while `enable_i`=0 despite `req_i`≠0.
- Timeout (`RR_ARBITER_TIMEOUT_EN`, `HOLD_MAX`=4): `req_i`=8'h03 held → `grant_o`=8'h01 for exactly 4 cycles, `timeout_o` pulses once, one bubble, then `grant_o`=8'h02 for 4 cycles.
